cluster_decoder: RTL and testbench
==================================

Name: cluster_decoder

Overview:
- Inverse of the cluster packer: takes one frame of up to 8 packed 14-bit clusters and rebuilds the 1536-strip S-bit hit map (24 VFATs x 64 strips).
- Used in the loopback/self-check path, where the expanded map is compared against the original VFAT S-bit words, and in the trigger-emulation path.
- Runs on clock4x.
- Decodes one cluster per cycle under a small FSM, then presents the completed map with a one-cycle valid strobe.

Parameters:
- NUM_CLUSTERS, 8, clusters per input frame.
- MXADRB, 11, cluster address width (strip index 0..1535).
- MXCNTB, 3, cluster size width; the field encodes strip count minus 1.
- NUM_STRIPS, 1536, total strips (24 x 64).

Ports:
- clock4x  input  1  design clock; all logic is synchronous to it.
- reset  input  1  asynchronous, active-high reset.
- clusters_valid  input  1  one-cycle strobe; cluster0..cluster7 are valid on this cycle.
- cluster0 .. cluster7  input  14 each  packed cluster {size[13:11], address[10:0]}.
- busy  output  1  high while a frame is latched or being expanded.
- sbits  output  1536  reconstructed hit map; bit n is strip n (VFAT n/64, channel n%64).
- sbits_valid  output  1  one-cycle pulse; sbits holds a complete frame.
- frame_dropped  output  1  sticky flag; a clusters_valid strobe arrived while busy. Cleared only by reset.
- overlap  output  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset values (asynchronous):
  - sbits = 0, sbits_valid = 0, busy = 0, frame_dropped = 0, overlap = 0.
  - FSM = IDLE; internal work map and index counter cleared.
- Reset asserted mid-expansion aborts the frame; no sbits_valid is issued for it.
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - On clusters_valid, latch all 8 clusters, clear the work map, set index = 0, assert busy next cycle, go to EXPAND.
- EXPAND (one cluster per cycle, in order cluster0 to cluster7):
  - Cluster is invalid if address >= NUM_STRIPS. Invalid clusters (including the packer's empty code 0x7FF) are skipped but still take their cycle. No early exit, so latency is fixed.
  - Valid cluster: OR bits address .. address+size into the work map (size+1 strips, 1 to 8).
  - Strips beyond NUM_STRIPS-1 are clipped; there is no wrap to strip 0.
  - Clusters may cross a VFAT boundary (for example address 63, size 1 sets bits 63 and 64).
  - Duplicate or overlapping clusters OR together.
  - After index 7, go to DONE.
- DONE:
  - Copy the work map to sbits and pulse sbits_valid for one cycle.
  - Deassert busy in the same cycle; return to IDLE.
- Latency: strobe at cycle T gives sbits_valid at cycle T+10 (1 latch + 8 expand + 1 done).
- sbits holds its value until the next DONE.
- Throughput: one frame per 10 cycles. A new clusters_valid is accepted in the IDLE cycle right after DONE.
- clusters_valid while busy (including on the DONE cycle): the frame is ignored and frame_dropped is set; the frame in progress is unaffected.
- Width rule: address+size is computed 12 bits wide, so no overflow before the clip comparison.

Optional Feature:
- Macro: CLUSTER_DECODER_OVERLAP_DET_EN.
- Defined:
  - During EXPAND, if any strip being set is already 1 in the work map, a per-frame overlap flag is set.
  - overlap is driven with that flag at DONE, aligned with sbits_valid, and held until the next DONE.
  - The flag resets per frame.
- Undefined: no detection logic; overlap is tied to 0.

Decomposition:
- Shared package cluster_pkg holds:
  - NUM_STRIPS, MXADRB, MXCNTB, NUM_CLUSTERS;
  - the invalid-address constant (0x7FF);
  - the cluster struct/field slices for address and size;
  - the FSM state encoding.
- One natural sub-module, cluster_mask_gen: combinational. Takes (address, size) and produces a 1536-bit mask with clipping and a valid bit. It is shared with the future packer self-check.

Test Plan:
- Single cluster: address 0x005 size 2, others 0x7FF, at T → at T+10 sbits_valid = 1 with only bits 5,6,7 set; busy is low at T+11.
- VFAT boundary and clip:
  - cluster0 = addr 63 size 1 → bits 63,64 set.
  - cluster1 = addr 1533 size 7 → bits 1533..1535 set, nothing else (no wrap).
- All invalid: 8 x 0x7FF → sbits = 0, sbits_valid still pulses at T+10.
- Back-to-back:
  - Strobe at T, second strobe at T+5 → second frame dropped, frame_dropped = 1, first frame decoded correctly.
  - Strobe at T+11 → accepted, output at T+21.
- Reset mid-frame: assert reset at T+4 → all outputs 0 immediately, no sbits_valid. The next frame after release decodes normally.
- Overlap (macro defined): cluster0 = addr 10 size 3, cluster1 = addr 12 size 0 → overlap = 1 at DONE, bits 10..13 set. Next disjoint frame → overlap = 0.

Source files
------------

// File: rtl/cluster_pkg.sv
// Shared cluster definitions: geometry, packed cluster layout and decoder FSM encoding.
package cluster_pkg;

  localparam int NUM_CLUSTERS = 8;
  localparam int MXADRB       = 11;
  localparam int MXCNTB       = 3;
  localparam int NUM_STRIPS   = 1536;
  localparam int CLW          = MXADRB + MXCNTB;
  localparam int IDXW         = $clog2(NUM_CLUSTERS);

  // Packer's "no cluster" address code
  localparam logic [MXADRB-1:0] ADR_INVALID = 11'h7FF;

  typedef struct packed {
    logic [MXCNTB-1:0] size;  // strip count minus 1
    logic [MXADRB-1:0] adr;
  } cluster_t;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  function automatic logic adr_valid(input logic [MXADRB-1:0] adr);
    return (adr != ADR_INVALID) && (adr < MXADRB'(NUM_STRIPS));
  endfunction

endpackage

// File: rtl/cluster_mask_gen.sv
// Combinational strip mask for one cluster: bits adr..adr+size, clipped at the top strip.
module cluster_mask_gen
  import cluster_pkg::*;
(
  input  logic [MXADRB-1:0]     adr,
  input  logic [MXCNTB-1:0]     size,
  output logic [NUM_STRIPS-1:0] mask,
  output logic                  valid
);

  logic [MXADRB:0] adr_lo;
  logic [MXADRB:0] adr_hi;

  // One extra bit so adr+size never wraps before the range compare
  assign valid  = adr_valid(adr);
  assign adr_lo = {1'b0, adr};
  assign adr_hi = adr_lo + {{(MXADRB + 1 - MXCNTB){1'b0}}, size};

  for (genvar i = 0; i < NUM_STRIPS; i++) begin : g_strip
    localparam logic [MXADRB:0] IDX = i;
    assign mask[i] = valid && (adr_lo <= IDX) && (IDX <= adr_hi);
  end

endmodule

// File: rtl/cluster_decoder.sv
// Expands a frame of 8 packed clusters into the 1536-strip hit map, one cluster per cycle.
// Optional overlap detection is enabled with CLUSTER_DECODER_OVERLAP_DET_EN.
module cluster_decoder
  import cluster_pkg::*;
(
  input  logic                  clock4x,
  input  logic                  reset,
  input  logic                  clusters_valid,
  input  logic [CLW-1:0]        cluster0,
  input  logic [CLW-1:0]        cluster1,
  input  logic [CLW-1:0]        cluster2,
  input  logic [CLW-1:0]        cluster3,
  input  logic [CLW-1:0]        cluster4,
  input  logic [CLW-1:0]        cluster5,
  input  logic [CLW-1:0]        cluster6,
  input  logic [CLW-1:0]        cluster7,
  output logic                  busy,
  output logic [NUM_STRIPS-1:0] sbits,
  output logic                  sbits_valid,
  output logic                  frame_dropped,
  output logic                  overlap
);

  logic [1:0]                          state_q, state_d;
  logic [IDXW-1:0]                     idx_q, idx_d;
  logic [NUM_CLUSTERS-1:0][CLW-1:0]    clu_q, clu_d;
  logic [NUM_CLUSTERS-1:0][CLW-1:0]    clu_in;
  logic [NUM_STRIPS-1:0]               work_q, work_d;
  logic [NUM_STRIPS-1:0]               sbits_q, sbits_d;
  logic                                sbits_valid_q, sbits_valid_d;
  logic                                drop_q, drop_d;
  logic [NUM_STRIPS-1:0]               mask;
  logic                                mask_vld;
  cluster_t                            cur;

  assign clu_in = {cluster7, cluster6, cluster5, cluster4,
                   cluster3, cluster2, cluster1, cluster0};
  assign cur    = cluster_t'(clu_q[idx_q]);

  cluster_mask_gen u_mask (
    .adr   (cur.adr),
    .size  (cur.size),
    .mask  (mask),
    .valid (mask_vld)
  );

`ifdef CLUSTER_DECODER_OVERLAP_DET_EN
  logic ovl_q, ovl_d;
  logic overlap_q, overlap_d;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    clu_d         = clu_q;
    work_d        = work_q;
    sbits_d       = sbits_q;
    sbits_valid_d = 1'b0;
    // Any strobe outside IDLE (DONE included) is lost and remembered
    drop_d        = drop_q | (clusters_valid && (state_q != S_IDLE));
`ifdef CLUSTER_DECODER_OVERLAP_DET_EN
    ovl_d         = ovl_q;
    overlap_d     = overlap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (clusters_valid) begin
          clu_d   = clu_in;
          work_d  = '0;
          idx_d   = '0;
          state_d = S_EXPAND;
`ifdef CLUSTER_DECODER_OVERLAP_DET_EN
          ovl_d   = 1'b0;
`endif
        end
      end
      S_EXPAND: begin
        if (mask_vld) begin
          work_d = work_q | mask;
`ifdef CLUSTER_DECODER_OVERLAP_DET_EN
          ovl_d  = ovl_q | (|(work_q & mask));
`endif
        end
        // Invalid clusters still burn their cycle so latency stays fixed
        idx_d = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NUM_CLUSTERS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        sbits_d       = work_q;
        sbits_valid_d = 1'b1;
        state_d       = S_IDLE;
`ifdef CLUSTER_DECODER_OVERLAP_DET_EN
        overlap_d     = ovl_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      clu_q         <= '0;
      work_q        <= '0;
      sbits_q       <= '0;
      sbits_valid_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      clu_q         <= clu_d;
      work_q        <= work_d;
      sbits_q       <= sbits_d;
      sbits_valid_q <= sbits_valid_d;
      drop_q        <= drop_d;
    end
  end

`ifdef CLUSTER_DECODER_OVERLAP_DET_EN
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      ovl_q     <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      ovl_q     <= ovl_d;
      overlap_q <= overlap_d;
    end
  end
  assign overlap = overlap_q;
`else
  assign overlap = 1'b0;
`endif

  assign busy          = (state_q != S_IDLE);
  assign sbits         = sbits_q;
  assign sbits_valid   = sbits_valid_q;
  assign frame_dropped = drop_q;

endmodule

// File: tb/tb_cluster_decoder.sv
// Directed scoreboard bench for cluster_decoder: stimulus queues expected maps, a monitor checks them.
module tb_cluster_decoder;

  localparam int NS = 1536;
`ifdef CLUSTER_DECODER_OVERLAP_DET_EN
  localparam logic OVL_EN = 1'b1;
`else
  localparam logic OVL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cv  = 1'b0;
  logic [13:0]   c [8];
  logic          busy, sv, fd, ovl;
  logic [NS-1:0] sbits;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NS-1:0] sb;
    logic          ov;
    int            at;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  cluster_decoder dut (
    .clock4x        (clk),
    .reset          (rst),
    .clusters_valid (cv),
    .cluster0       (c[0]),
    .cluster1       (c[1]),
    .cluster2       (c[2]),
    .cluster3       (c[3]),
    .cluster4       (c[4]),
    .cluster5       (c[5]),
    .cluster6       (c[6]),
    .cluster7       (c[7]),
    .busy           (busy),
    .sbits          (sbits),
    .sbits_valid    (sv),
    .frame_dropped  (fd),
    .overlap        (ovl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NS-1:0] rng(input int lo, input int hi);
    logic [NS-1:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [13:0] cl(input int sz, input int adr);
    return {3'(sz), 11'(adr)};
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_map(input string nm, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    int first;
    total++;
    if (act !== exp) begin
      bad++;
      first = -1;
      for (int i = 0; i < NS; i++) if (first < 0 && act[i] !== exp[i]) first = i;
      $display("FAIL %s: got %0d bits set, want %0d bits set, first diff at strip %0d (cycle %0d)",
               nm, $countones(act), $countones(exp), first, cyc);
    end
  endtask

  // Monitor: every sbits_valid must match the oldest queued frame, on its exact cycle
  always @(negedge clk) begin
    if (sv) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sbits_valid: got pulse at cycle %0d want none", cyc);
      end else begin
        mon_e = q.pop_front();
        chk_map("sbits", sbits, mon_e.sb);
        chk_int("valid_cycle", cyc, mon_e.at);
        chk_bit("overlap", ovl, mon_e.ov);
      end
    end
  end

  task automatic clr();
    for (int i = 0; i < 8; i++) c[i] = cl(0, 'h7FF);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic push, input logic [NS-1:0] e, input logic eo);
    exp_t x;
    cv = 1'b1;
    if (push) begin
      x.sb = e;
      x.ov = eo;
      x.at = cyc + 10;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    cv = 1'b0;
  endtask

  int k;

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk_map("reset_sbits", sbits, '0);
    chk_bit("reset_valid", sv, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_dropped", fd, 1'b0);
    chk_bit("reset_overlap", ovl, 1'b0);
    rst = 1'b0;
    wait_until(cyc + 2);

    // Single cluster, strips 5..7
    clr();
    c[0] = cl(2, 5);
    k = cyc;
    strobe(1'b1, rng(5, 7), 1'b0);
    chk_bit("busy_after_strobe", busy, 1'b1);
    wait_until(k + 11);
    chk_bit("busy_after_done", busy, 1'b0);
    chk_bit("no_drop_yet", fd, 1'b0);

    // VFAT boundary, top clip, out-of-range and empty codes
    clr();
    c[0] = cl(1, 63);
    c[1] = cl(7, 1533);
    c[2] = cl(0, 1536);
    c[3] = cl(7, 'h7FF);
    k = cyc;
    strobe(1'b1, rng(63, 64) | rng(1533, 1535), 1'b0);
    wait_until(k + 12);

    // All invalid still produces an (empty) frame
    clr();
    c[5] = cl(3, 2000);
    k = cyc;
    strobe(1'b1, '0, 1'b0);
    wait_until(k + 12);

    // Back-to-back: mid-frame and DONE-cycle strobes are dropped
    clr();
    c[0] = cl(0, 100);
    c[1] = cl(4, 1530);
    k = cyc;
    strobe(1'b1, rng(100, 100) | rng(1530, 1534), 1'b0);
    wait_until(k + 5);
    clr();
    c[0] = cl(0, 200);
    strobe(1'b0, '0, 1'b0);
    chk_bit("dropped_set", fd, 1'b1);
    wait_until(k + 9);
    c[0] = cl(0, 300);
    strobe(1'b0, '0, 1'b0);
    wait_until(k + 11);
    clr();
    c[0] = cl(7, 0);
    c[1] = cl(0, 8);
    strobe(1'b1, rng(0, 8), 1'b0);
    wait_until(k + 23);
    chk_bit("dropped_sticky", fd, 1'b1);

    // Reset mid-frame aborts it and clears everything
    clr();
    c[0] = cl(0, 400);
    k = cyc;
    strobe(1'b0, '0, 1'b0);
    wait_until(k + 4);
    rst = 1'b1;
    #1;
    chk_map("abort_sbits", sbits, '0);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_dropped", fd, 1'b0);
    chk_bit("abort_valid", sv, 1'b0);
    wait_until(cyc + 2);
    rst = 1'b0;
    wait_until(cyc + 14);

    // Normal frame after reset
    clr();
    c[0] = cl(3, 320);
    c[1] = cl(0, 1535);
    k = cyc;
    strobe(1'b1, rng(320, 323) | rng(1535, 1535), 1'b0);
    wait_until(k + 12);

    // Overlapping clusters OR together
    clr();
    c[0] = cl(3, 10);
    c[1] = cl(0, 12);
    k = cyc;
    strobe(1'b1, rng(10, 13), OVL_EN);
    wait_until(k + 13);
    chk_bit("overlap_held", ovl, OVL_EN);

    // Disjoint frame clears the overlap flag
    clr();
    c[0] = cl(0, 20);
    c[7] = cl(1, 22);
    k = cyc;
    strobe(1'b1, rng(20, 20) | rng(22, 23), 1'b0);
    wait_until(k + 14);

    chk_int("pending_frames", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
